// File: rtl/rf_wb_arb_pkg.sv
// Shared defaults, request layout and lowest-set-bit helper for the register-file write-port arbiter.
package rf_wb_arb_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUM_REGISTERS = 32;
  localparam int DEF_N_REQ         = 3;
  localparam int DEF_ADDR_W        = $clog2(DEF_NUM_REGISTERS);

  // Widest request vector the helper handles; pickers must stay strictly narrower.
  localparam int PICK_W = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]     rd;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [PICK_W-1:0] lowest_onehot(input logic [PICK_W-1:0] v);
    return v & (~v + PICK_W'(1));
  endfunction

endpackage

// File: rtl/rf_wb_arb_pick.sv
// Combinational one-hot picker: lowest-index set bit of req wins, zero when req is zero.
module rf_wb_arb_pick
  import rf_wb_arb_pkg::*;
#(
  parameter int N = DEF_N_REQ
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic [PICK_W-1:0] wide;
  logic              unused_hi;

  assign wide      = lowest_onehot(PICK_W'(req));
  assign grant     = wide[N-1:0];
  // Zero-extended input, so the bits above N can never be set.
  assign unused_hi = |wide[PICK_W-1:N];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: fixed priority (index 0 highest), grant is combinational,
// write presented one cycle after acceptance, output side never stalls. Aging: RF_WB_ARB_AGING_EN.
module rf_wb_arbiter
  import rf_wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
  parameter int N_REQ         = DEF_N_REQ,
  parameter int MAX_WAIT      = 7,
  localparam int ADDR_W       = $clog2(NUM_REGISTERS)
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [N_REQ-1:0]            req_valid_in,
  input  logic [N_REQ*ADDR_W-1:0]     req_rd_in,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [N_REQ-1:0]            req_ready_out,
  output logic                        wr_en_out,
  output logic [ADDR_W-1:0]           rd_out,
  output logic [DATA_WIDTH-1:0]       rd_data_out,
  output logic                        busy_out
);

  // Same layout as wb_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0]     rd;
    logic [DATA_WIDTH-1:0] data;
  } slot_t;

  logic [N_REQ-1:0] valid_pick;
  logic [N_REQ-1:0] grant;
  slot_t            sel;

  rf_wb_arb_pick #(.N(N_REQ)) u_pick_valid (
    .req   (req_valid_in),
    .grant (valid_pick)
  );

`ifdef RF_WB_ARB_AGING_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [N_REQ-1:0] urgent;
  logic [N_REQ-1:0] urgent_pick;

  // Requester 0 already has top priority and never needs to age.
  assign urgent[0] = 1'b0;

  for (genvar i = 1; i < N_REQ; i++) begin : g_age
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        wait_cnt <= '0;
      end else if (!req_valid_in[i] || grant[i]) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end

    // Gate with valid: a saturated count is stale in the cycle valid drops.
    assign urgent[i] = req_valid_in[i] && (wait_cnt == WAIT_W'(MAX_WAIT));
  end

  rf_wb_arb_pick #(.N(N_REQ)) u_pick_urgent (
    .req   (urgent),
    .grant (urgent_pick)
  );

  assign grant = (|urgent_pick) ? urgent_pick : valid_pick;
`else
  localparam int unused_max_wait = MAX_WAIT;

  assign grant = valid_pick;
`endif

  assign req_ready_out = grant;
  assign busy_out      = |(req_valid_in & ~grant);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.rd   = req_rd_in[i*ADDR_W +: ADDR_W];
        sel.data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register 0 is hardwired: the request is consumed but never written.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_en_out   <= 1'b0;
      rd_out      <= '0;
      rd_data_out <= '0;
    end else if (|grant) begin
      wr_en_out   <= (sel.rd != '0);
      rd_out      <= sel.rd;
      rd_data_out <= sel.data;
    end else begin
      wr_en_out   <= 1'b0;
    end
  end

  always_comb begin
    if (!arst) begin
      assert ((grant & (grant - N_REQ'(1))) == '0);
      assert ((grant & ~req_valid_in) == '0);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, directed corner sequences, random traffic vs model.
module tb_rf_wb_arbiter;

  localparam int N_REQ    = 3;
  localparam int MAX_WAIT = 7;

  logic        clk = 1'b0;
  logic        arst;
  logic [2:0]  req_valid_in;
  logic [14:0] req_rd_in;
  logic [95:0] req_data_in;
  logic [2:0]  req_ready_out;
  logic        wr_en_out;
  logic [4:0]  rd_out;
  logic [31:0] rd_data_out;
  logic        busy_out;

  logic [4:0]  r_rd   [N_REQ];
  logic [31:0] r_data [N_REQ];

  assign req_rd_in   = {r_rd[2], r_rd[1], r_rd[0]};
  assign req_data_in = {r_data[2], r_data[1], r_data[0]};

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .DATA_WIDTH    (32),
    .NUM_REGISTERS (32),
    .N_REQ         (N_REQ),
    .MAX_WAIT      (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .req_valid_in  (req_valid_in),
    .req_rd_in     (req_rd_in),
    .req_data_in   (req_data_in),
    .req_ready_out (req_ready_out),
    .wr_en_out     (wr_en_out),
    .rd_out        (rd_out),
    .rd_data_out   (rd_data_out),
    .busy_out      (busy_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles each requester has waited, and the write the register file should see.
  int          age [N_REQ];
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  e_ready;
    logic        e_busy;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_wen  = 1'b0;
    m_rd   = '0;
    m_data = '0;
    for (int i = 0; i < N_REQ; i++) age[i] = 0;
  endtask

  function automatic int model_winner();
    int w = -1;
`ifdef RF_WB_ARB_AGING_EN
    for (int i = N_REQ - 1; i >= 1; i--)
      if (req_valid_in[i] && age[i] >= MAX_WAIT) w = i;
    if (w >= 0) return w;
`endif
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid_in[i]) w = i;
    return w;
  endfunction

  // One clock: check everything at the falling edge, then advance the model across the rising edge.
  task automatic step(output int w);
    logic [2:0] e_ready;
    @(negedge clk);
    w       = model_winner();
    e_ready = (w < 0) ? 3'b000 : 3'(1 << w);
    chk("ready", req_ready_out, e_ready);
    chk("busy", busy_out, (req_valid_in & ~e_ready) != 3'b000);
    chk("wr_en", wr_en_out, m_wen);
    chk("rd", rd_out, m_rd);
    chk("data", rd_data_out, m_data);
    @(posedge clk);
    if (w >= 0) begin
      m_rd   = r_rd[w];
      m_data = r_data[w];
      m_wen  = (r_rd[w] != 5'd0);
    end else begin
      m_wen = 1'b0;
    end
    for (int i = 0; i < N_REQ; i++)
      age[i] = (req_valid_in[i] && i != w) ? age[i] + 1 : 0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int order [$];
    int pulses;
    int n_wait;

    tv[0] = '{3'b010, 5'd1, 5'd5, 5'd2, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tv[1] = '{3'b111, 5'd3, 5'd4, 5'd6, 32'h11111111, 32'h2222, 32'h3333, 3'b001, 1'b1, 1'b1, 5'd3, 32'h11111111};
    tv[2] = '{3'b110, 5'd3, 5'd9, 5'd6, 32'h0, 32'h22, 32'h33, 3'b010, 1'b1, 1'b1, 5'd9, 32'h22};
    tv[3] = '{3'b100, 5'd0, 5'd0, 5'd31, 32'h0, 32'h0, 32'h33, 3'b100, 1'b0, 1'b1, 5'd31, 32'h33};
    tv[4] = '{3'b001, 5'd0, 5'd8, 5'd8, 32'h1234, 32'h0, 32'h0, 3'b001, 1'b0, 1'b0, 5'd0, 32'h1234};
    tv[5] = '{3'b000, 5'd7, 5'd7, 5'd7, 32'h5, 32'h5, 32'h5, 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234};
    tv[6] = '{3'b101, 5'd31, 5'd0, 5'd1, 32'hFFFFFFFF, 32'h0, 32'h77, 3'b001, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
    tv[7] = '{3'b110, 5'd2, 5'd0, 5'd4, 32'h0, 32'h5555, 32'h66, 3'b010, 1'b1, 1'b0, 5'd0, 32'h5555};

    // Reset with every requester valid.
    arst         = 1'b0;
    req_valid_in = 3'b111;
    for (int i = 0; i < N_REQ; i++) begin
      r_rd[i]   = 5'(i + 1);
      r_data[i] = 32'hA000_0000 + 32'(i);
    end
    #2 arst = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en_out, 1'b0);
    chk("rst_rd", rd_out, 5'd0);
    chk("rst_data", rd_data_out, 32'd0);
    chk("rst_ready", req_ready_out, 3'b001);
    @(posedge clk);
    #1 arst = 1'b0;
    step(w);
    req_valid_in = 3'b000;
    step(w);
    step(w);

    // Isolated single-cycle vectors, each followed by an idle cycle that shows the write.
    foreach (tv[k]) begin
      req_valid_in = tv[k].valid;
      r_rd[0] = tv[k].rd0; r_rd[1] = tv[k].rd1; r_rd[2] = tv[k].rd2;
      r_data[0] = tv[k].d0; r_data[1] = tv[k].d1; r_data[2] = tv[k].d2;
      @(negedge clk);
      chk($sformatf("tv%0d_ready", k), req_ready_out, tv[k].e_ready);
      chk($sformatf("tv%0d_busy", k), busy_out, tv[k].e_busy);
      @(posedge clk);
      #1 req_valid_in = 3'b000;
      @(negedge clk);
      chk($sformatf("tv%0d_wr_en", k), wr_en_out, tv[k].e_wen);
      chk($sformatf("tv%0d_rd", k), rd_out, tv[k].e_rd);
      chk($sformatf("tv%0d_data", k), rd_data_out, tv[k].e_data);
      chk($sformatf("tv%0d_idle_ready", k), req_ready_out, 3'b000);
      @(posedge clk);
      #1;
    end
    reset_model();
    m_rd   = tv[7].e_rd;
    m_data = tv[7].e_data;

    // Contention: all valid and held; each winner drops after acceptance.
    for (int i = 0; i < N_REQ; i++) begin
      r_rd[i]   = 5'(i + 1);
      r_data[i] = 32'hC0DE_0000 + 32'(i);
    end
    req_valid_in = 3'b111;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step(w);
      if (w >= 0) begin
        order.push_back(w);
        req_valid_in[w] = 1'b0;
      end
      if (wr_en_out) pulses++;
    end
    chk("cont_grants", order.size(), 3);
    if (order.size() == 3) begin
      chk("cont_first", order[0], 0);
      chk("cont_second", order[1], 1);
      chk("cont_third", order[2], 2);
    end
    chk("cont_pulses", pulses, 3);

    // Back-to-back writes from requester 0.
    req_valid_in = 3'b001;
    for (int c = 0; c < 4; c++) begin
      r_rd[0]   = 5'(c + 20);
      r_data[0] = $urandom;
      step(w);
      chk("b2b_winner", w, 0);
    end
    req_valid_in = 3'b000;
    step(w);

    // Requester 2 waiting behind a never-idle requester 0.
    r_rd[2]   = 5'd7;
    r_data[2] = 32'h7777_0002;
    req_valid_in = 3'b101;
    n_wait = -1;
    for (int c = 0; c < 12 && n_wait < 0; c++) begin
      r_rd[0]   = 5'(c + 1);
      r_data[0] = $urandom;
      step(w);
      if (w == 2) n_wait = c + 1;
    end
`ifdef RF_WB_ARB_AGING_EN
    chk("age_wait", n_wait, 8);
`else
    chk("age_wait", n_wait, -1);
`endif
    req_valid_in[2] = 1'b0;
    step(w);
    chk("age_resume", w, 0);

    // Reset while an accepted write is pending and requester 2 has aged.
    req_valid_in = 3'b101;
    for (int c = 0; c < 4; c++) begin
      r_rd[0]   = 5'(10 + c);
      r_data[0] = $urandom;
      step(w);
    end
    req_valid_in = 3'b110;
    r_rd[1]   = 5'd6;
    r_data[1] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("mr_ready", req_ready_out, 3'b010);
    #2 arst = 1'b1;
    #1 chk("mr_wen_now", wr_en_out, 1'b0);
    @(posedge clk);
    #1;
    chk("mr_wen", wr_en_out, 1'b0);
    chk("mr_rd", rd_out, 5'd0);
    chk("mr_data", rd_data_out, 32'd0);
    reset_model();
    arst = 1'b0;
    req_valid_in = 3'b101;
    n_wait = -1;
    for (int c = 0; c < 12 && n_wait < 0; c++) begin
      r_data[0] = $urandom;
      step(w);
      if (w == 2) n_wait = c + 1;
    end
`ifdef RF_WB_ARB_AGING_EN
    chk("mr_age_wait", n_wait, 8);
`else
    chk("mr_age_wait", n_wait, -1);
`endif

    // Random traffic: held requests, occasional early drops, frequent writes to register 0.
    for (int c = 0; c < 400; c++) begin
      step(w);
      if (w >= 0) req_valid_in[w] = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid_in[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid_in[i] = 1'b1;
            r_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r_data[i] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid_in[i] = 1'b0;
        end
      end
    end
    req_valid_in = 3'b000;
    step(w);
    step(w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the integer register file. Several writeback sources (in-order pipeline writeback, load unit, multi-cycle mul/div) compete for the register file's single write port. The arbiter accepts at most one write per cycle through a valid/ready handshake and drives a registered write (enable, address, data) into the register file. Selection is fixed-priority, with optional age-based anti-starvation.

## Interface
- `DATA_WIDTH`, 32, register data width.
- `NUM_REGISTERS`, 32, register count; `ADDR_W = $clog2(NUM_REGISTERS)`.
- `N_REQ`, 3, number of requesters; index 0 has the highest priority.
- `MAX_WAIT`, 7, age threshold in cycles (used only with the aging feature); `WAIT_W = $clog2(MAX_WAIT+1)`.
- `clk` input, 1: single clock, rising edge.
- `arst` input, 1: asynchronous, active-high reset.
- `req_valid_in` input, `N_REQ`: per-requester write request.
- `req_rd_in` input, `N_REQ×ADDR_W`: destination register address per requester.
- `req_data_in` input, `N_REQ×DATA_WIDTH`: write data per requester.
- `req_ready_out` output, `N_REQ`: one-hot (or zero) grant; a request is accepted when valid and ready are both high.
- `wr_en_out` output, 1: register file write enable.
- `rd_out` output, `ADDR_W`: register file write address.
- `rd_data_out` output, `DATA_WIDTH`: register file write data.
- `busy_out` output, 1: high when any `req_valid_in` is not granted this cycle.

## Operation
- Grant is combinational from `req_valid_in` and the aging state. At most one bit of `req_ready_out` is set. `req_ready_out[i]` never depends on anything other than the valids and the registered state.
- Base policy: the lowest-index valid requester wins.
- An accepted request updates the output register at the next rising edge. `wr_en_out` is high for exactly that one cycle per accepted request.
- Writes to register 0:
  - Accepted normally (ready asserted).
  - `wr_en_out` stays 0.
  - `rd_out` and `rd_data_out` still load the request values.
- When no request is accepted, `wr_en_out` is 0 and `rd_out`/`rd_data_out` hold their last values.
- Requester rule: once asserted, valid, rd and data stay stable until accepted. Dropping valid early is tolerated: the request is discarded and no write occurs.
- Throughput: one write per cycle sustained. The arbiter never back-pressures the output side, because the register file always accepts.

## Timing
- Reset values (asynchronous): `wr_en_out`=0, `rd_out`=0, `rd_data_out`=0, all wait counters 0. `req_ready_out` and `busy_out` follow the combinational rules (both 0 while all valids are low).
- Latency: accepted in cycle N, presented on `wr_en_out` in cycle N+1. The register file captures it on the falling edge within N+1, so the data is readable from N+1's second half.
- Simultaneous valids: exactly one is granted. The losers hold their requests and are reconsidered every cycle.
- Reset mid-operation: the pending output write is cancelled (`wr_en_out` forced to 0 immediately), counters clear, and there is no replay.
- Back-to-back requests from the same requester in consecutive cycles are all accepted if it keeps winning.

## Configuration
- Macro `RF_WB_ARB_AGING_EN`.
- Defined:
  - Each requester i ≥ 1 has a saturating `WAIT_W` counter.
  - The counter increments each cycle valid is high and the request is not granted. It clears on grant or when valid is low.
  - At `MAX_WAIT`, requester i becomes urgent.
  - Any urgent requester beats every non-urgent one; ties among urgent requesters go to the lowest index.
  - Worst-case wait for any requester is bounded by `MAX_WAIT + N_REQ − 1` cycles.
- Undefined: pure fixed priority, no counters synthesized, and `MAX_WAIT` is ignored.

## Structure
- Package `rf_wb_arb_pkg`:
  - Default constants for `DATA_WIDTH`, `NUM_REGISTERS` and `N_REQ`.
  - `wb_req_t` struct (rd, data).
  - Function returning the one-hot lowest set bit.
- Sub-module `rf_wb_arb_pick`: combinational one-hot priority picker over `N_REQ` bits. It is instantiated once for the urgent mask and once for the valid mask; the urgent result is selected when non-zero.
- Top level: grant logic, wait counters, output register.

## Test plan
- Reset: assert `arst` with all valids high → `wr_en_out`=0, `rd_out`=0, `rd_data_out`=0. After release, requester 0 is granted first.
- Single request: req1 with rd=5, data=0xDEADBEEF → `req_ready_out`=3'b010 in cycle N. In N+1: `wr_en_out`=1, `rd_out`=5, `rd_data_out`=0xDEADBEEF.
- Contention: all three valid, held → grants in order 0, then 1 after 0 drops, then 2. Exactly one `wr_en_out` pulse per grant.
- Register 0 write: req0 with rd=0, data=0x1234 → ready=1 and `wr_en_out` stays 0 in the next cycle.
- Aging on, `MAX_WAIT`=7: req0 valid continuously with new data each cycle, req2 valid → req2 granted in its 8th waiting cycle, then req0 resumes.
- Mid-operation reset: accept req1 in cycle N, assert `arst` before edge N+1 → `wr_en_out` stays 0, counters read 0.
